// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its picker.
package uart_tx_arb_pkg;

    // Width of one UART byte.
    localparam int BYTE_W = 8;

    // Arbiter states: waiting for a request, or a requester owns the transmitter.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for a requester count; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: returns the first set request scanning
// upward from rr_ptr+1 with wrap-around. Kept generic for reuse on the RX side.
module uart_rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any_req
);

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        int idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (req[idx[ID_W-1:0]]) begin
                winner  = ID_W'(idx);
                any_req = 1'b1;
            end else begin
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit port between N_REQ byte
// streams. A grant lasts for a whole message (until req_last) or until
// MAX_BURST bytes have been sent, after which arbitration runs again.
// Optional stall timeout: define UART_TX_ARB_TIMEOUT_EN to build it.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int MAX_BURST      = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ID_W          = id_width(N_REQ)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*BYTE_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    uart_full,
    output logic                    uart_wr_en,
    output logic [BYTE_W-1:0]       uart_tx_data,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    timeout_err
);

    localparam logic [7:0] MAX_C     = 8'(MAX_BURST);
    localparam bit         PARAMS_OK = (N_REQ >= 2) && (N_REQ <= 16) &&
                                       (MAX_BURST >= 1) && (MAX_BURST <= 255) &&
                                       (TIMEOUT_CYCLES >= 2);

    if (!PARAMS_OK) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_e             state_r, state_s;
    logic [ID_W-1:0]        grant_id_r, grant_id_s;
    logic [ID_W-1:0]        rr_ptr_r, rr_ptr_s;
    logic [7:0]             byte_cnt_r, byte_cnt_s;
    logic [ID_W-1:0]        winner_s;
    logic                   any_req_s;
    logic [N_REQ-1:0]       ready_s;
    logic                   wr_en_s;
    logic [BYTE_W-1:0]      tx_data_s;
    logic [BYTE_W-1:0]      grant_data_s;
    logic                   timeout_hit_s;

    uart_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // Only the grantee's byte lane is ever selected.
    assign grant_data_s = req_data[BYTE_W*int'(grant_id_r) +: BYTE_W];

    // Next-state logic plus the zero-latency pass-through of the grantee.
    always_comb begin
        state_s    = state_r;
        grant_id_s = grant_id_r;
        rr_ptr_s   = rr_ptr_r;
        byte_cnt_s = byte_cnt_r;
        ready_s    = '0;
        wr_en_s    = 1'b0;
        tx_data_s  = '0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s    = GRANT;
                    grant_id_s = winner_s;
                    byte_cnt_s = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                ready_s[grant_id_r] = ~uart_full;
                wr_en_s             = req_valid[grant_id_r] & ~uart_full;
                if (wr_en_s) begin
                    tx_data_s = grant_data_s;
                    if (byte_cnt_r == MAX_C) begin
                        byte_cnt_s = byte_cnt_r;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 8'd1;
                    end
                    // End of message or burst limit hands the port back.
                    if (req_last[grant_id_r] || ((byte_cnt_r + 8'd1) == MAX_C)) begin
                        state_s  = IDLE;
                        rr_ptr_s = grant_id_r;
                    end else begin
                        state_s = GRANT;
                    end
                end else if (timeout_hit_s) begin
                    state_s  = IDLE;
                    rr_ptr_s = grant_id_r;
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= ID_W'(N_REQ - 1);
            byte_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            grant_id_r <= grant_id_s;
            rr_ptr_r   <= rr_ptr_s;
            byte_cnt_r <= byte_cnt_s;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    logic [TO_W-1:0] stall_cnt_r;
    logic            stall_s;
    logic            timeout_err_r;

    // A stall cycle that would take the count to TIMEOUT_CYCLES-1 aborts the grant.
    always_comb begin
        stall_s       = (state_r == GRANT) & ~req_valid[grant_id_r] & ~uart_full;
        timeout_hit_s = stall_s & (stall_cnt_r == TO_LAST);
    end

    // Stall counter: idle-grantee cycles only; full-stalls are not counted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_r   <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_hit_s;
            if ((state_r != GRANT) || wr_en_s || timeout_hit_s) begin
                stall_cnt_r <= '0;
            end else if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + TO_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    assign req_ready    = ready_s;
    assign uart_wr_en   = wr_en_s;
    assign uart_tx_data = tx_data_s;
    assign busy         = (state_r == GRANT);
    assign grant_id     = grant_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=4, TIMEOUT_CYCLES=8).
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           Clk;
    logic           Reset;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           uart_full;
    logic           uart_wr_en;
    logic [7:0]     uart_tx_data;
    logic           busy;
    logic [1:0]     grant_id;
    logic           timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  rq [N][$];
    logic [11:0] exp_q [$];

    uart_tx_arbiter #(
        .N_REQ          (N),
        .MAX_BURST      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_full    (uart_full),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_data (uart_tx_data),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #2;
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic last);
        rq[id].push_back({last, d});
    endtask

    task automatic expect_wr(input int id, input logic [7:0] d);
        exp_q.push_back({4'(id), d});
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0);
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (pending() && (n < max_cycles)) begin
            step();
            n++;
        end
        chk("drain_scoreboard_empty", exp_q.size(), 0);
        repeat (2) step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) step();
        Reset = 1'b0;
        step();
    endtask

    // Requester model: presents queue heads at negedge, pops on valid&ready.
    initial begin
        logic [N-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge Clk);
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            #4;
            acc = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && (rq[i].size() > 0)) void'(rq[i].pop_front());
            end
        end
    end

    // Monitor: every UART write must match the next expected (id, byte).
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge Clk);
            #4;
            if (uart_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h expected=none", uart_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_grant_id", grant_id, e[11:8]);
                    chk("wr_data", uart_tx_data, e[7:0]);
                end
            end
        end
    end

    initial begin
        Reset     = 1'b1;
        uart_full = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_wr_en", uart_wr_en, 0);
        chk("rst_tx_data", uart_tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_timeout_err", timeout_err, 0);
        Reset = 1'b0;
        step();

        // 1: single requester, three-byte message.
        send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b0); send(0, 8'h43, 1'b1);
        expect_wr(0, 8'h41); expect_wr(0, 8'h42); expect_wr(0, 8'h43);
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_wr_en", uart_wr_en, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_wr_en", uart_wr_en, 1);
            chk("t1_busy", busy, 1);
            chk("t1_grant_id", grant_id, 0);
        end
        step();
        chk("t1_busy_drop", busy, 0);
        wait_drain(20);

        // 2: simultaneous one-byte messages, round-robin order from reset.
        do_reset();
        send(0, 8'h10, 1'b1); send(1, 8'h11, 1'b1); send(2, 8'h12, 1'b1);
        expect_wr(0, 8'h10); expect_wr(1, 8'h11); expect_wr(2, 8'h12);
        wait_drain(40);
        send(0, 8'h20, 1'b1); send(0, 8'h23, 1'b1);
        send(1, 8'h21, 1'b1); send(2, 8'h22, 1'b1);
        expect_wr(0, 8'h20); expect_wr(1, 8'h21); expect_wr(2, 8'h22); expect_wr(0, 8'h23);
        wait_drain(40);

        // 3: uart_full stalls a granted byte for five cycles.
        uart_full = 1'b1;
        send(1, 8'h55, 1'b1);
        expect_wr(1, 8'h55);
        step();
        chk("t3_idle_busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_busy", busy, 1);
            chk("t3_ready_low", req_ready, 0);
            chk("t3_wr_en_low", uart_wr_en, 0);
        end
        step();
        uart_full = 1'b0;
        #1;
        chk("t3_release_wr_en", uart_wr_en, 1);
        chk("t3_release_data", uart_tx_data, 8'h55);
        chk("t3_release_ready", req_ready, 4'b0010);
        wait_drain(20);

        // 4: burst limit of 4 interleaves req 3 inside req 2's long message.
        for (int b = 0; b < 6; b++) send(2, 8'(8'h60 + b), (b == 5));
        send(3, 8'h70, 1'b0); send(3, 8'h71, 1'b1);
        expect_wr(2, 8'h60); expect_wr(2, 8'h61); expect_wr(2, 8'h62); expect_wr(2, 8'h63);
        expect_wr(3, 8'h70); expect_wr(3, 8'h71);
        expect_wr(2, 8'h64); expect_wr(2, 8'h65);
        wait_drain(60);

        // 5: reset mid-message after two bytes.
        for (int b = 0; b < 5; b++) send(0, 8'(8'h80 + b), (b == 4));
        expect_wr(0, 8'h80); expect_wr(0, 8'h81);
        step();
        step();
        step();
        Reset = 1'b1;
        rq[0].delete();
        step();
        chk("t5_busy", busy, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_wr_en", uart_wr_en, 0);
        chk("t5_grant_id", grant_id, 0);
        chk("t5_tx_data", uart_tx_data, 0);
        Reset = 1'b0;
        wait_drain(20);

        // 6: grantee goes silent after one byte while req 3 waits.
        send(1, 8'h90, 1'b0);
        expect_wr(1, 8'h90);
`ifdef UART_TX_ARB_TIMEOUT_EN
        expect_wr(3, 8'h95);
`endif
        step();
        step();
        chk("t6_first_byte", uart_wr_en, 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) send(3, 8'h95, 1'b1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            chk("t6_timeout_err", timeout_err, (k == 8) ? 1 : 0);
            if (k < 8) begin
                chk("t6_busy_held", busy, 1);
                chk("t6_grant_held", grant_id, 1);
            end else if (k == 8) begin
                chk("t6_abort_busy", busy, 0);
            end
`else
            chk("t6_busy_held", busy, 1);
            chk("t6_grant_held", grant_id, 1);
            chk("t6_timeout_err", timeout_err, 0);
            chk("t6_no_write", uart_wr_en, 0);
`endif
        end
`ifndef UART_TX_ARB_TIMEOUT_EN
        Reset = 1'b1;
        rq[3].delete();
        step();
        Reset = 1'b0;
`endif
        wait_drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the UART transmit path (TX_data / wr_uart_en / Full) between N_REQ byte-stream requesters, e.g. CPU console, debug monitor and trace unit.
- Each grant covers a whole message: the granted requester keeps the transmitter until it marks a byte as last, or until a burst byte limit is reached.
- Arbitration is round-robin, so no requester can starve another.
- The block sits between the requesters and the UART top, and drives its transmit write port directly.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_BURST, 64, maximum bytes per grant before a forced re-arbitration (1..255).
- TIMEOUT_CYCLES, 1024, stall limit for the optional timeout feature (≥2).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ×8  per-requester byte, packed, requester i at bits [8i+7:8i].
- req_last  in  N_REQ  qualifies req_valid: this byte ends the message.
- req_ready  out  N_REQ  byte accepted when valid&ready.
- uart_full  in  1  UART transmit FIFO full.
- uart_wr_en  out  1  write strobe to the UART.
- uart_tx_data  out  8  byte to the UART.
- busy  out  1  a grant is active.
- grant_id  out  $clog2(N_REQ)  index of the current or most recent grantee.
- timeout_err  out  1  one-cycle pulse on a forced abort (optional feature).

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=N_REQ-1, grant_id=0, byte_cnt=0.
  - req_ready=0, uart_wr_en=0, uart_tx_data=0, busy=0, timeout_err=0.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from rr_ptr+1 upward with wrap (mod N_REQ).
  - Register the winner into grant_id and set byte_cnt=0; the next state is GRANT.
  - No bytes are accepted in IDLE, so arbitration costs one cycle.
- GRANT, outputs (combinational from registered state):
  - req_ready[grant_id] = ~uart_full; every other req_ready is 0.
  - uart_wr_en = req_valid[grant_id] & ~uart_full.
  - uart_tx_data = req_data[grant_id] when uart_wr_en=1, else 0.
  - Zero-latency pass-through: exactly one UART write per accepted byte.
- GRANT, transfer (valid&ready on the grantee):
  - byte_cnt increments (8-bit, saturating at MAX_BURST).
  - If req_last=1 or byte_cnt+1==MAX_BURST: next state IDLE, rr_ptr<=grant_id.
  - A message longer than MAX_BURST continues after re-arbitration. If it is the only requester, it is re-granted after exactly one IDLE cycle.
- busy=1 exactly while state==GRANT.
- Deassertion of req_valid by the grantee mid-message does not release the grant; the arbiter waits.
- uart_full=1 stalls the transfer; req_ready and uart_wr_en both stay 0. Data is never dropped and never written while full.
- Simultaneous requests in IDLE resolve only by round-robin order; a fixed index never has priority.
- A requester raising req_valid during another's grant waits for that grant to end.
- Reset asserted mid-message: the arbiter returns to IDLE next cycle with all outputs at reset values. A partially sent message is not resumed or flagged.
- The arbiter never reads req_data of non-granted requesters.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro:
  - A stall counter counts GRANT cycles where req_valid[grant_id]=0 and uart_full=0. It clears on any accepted byte and on entry to GRANT.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE, sets rr_ptr<=grant_id and pulses timeout_err for 1 cycle.
  - Cycles stalled on uart_full are not counted.
- Without the macro: no counter is built, timeout_err is tied to 0, and a stalled grantee holds the grant indefinitely.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state enum (IDLE, GRANT);
  - localparam ID_W = $clog2(N_REQ) helper function;
  - byte width constant 8.
- Sub-module uart_rr_picker: combinational round-robin priority picker. Inputs req vector and rr_ptr; outputs winner index and any_req. It is reusable for a later RX demultiplexer.

Test Plan:
1. Only req 0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, uart_full=0 → 1 IDLE cycle, then 3 consecutive uart_wr_en pulses with those bytes, grant_id=0; busy drops the cycle after 0x43.
2. Reqs 0,1,2 all valid with 1-byte messages at once, rr_ptr=3 after reset → service order 0,1,2. Repeat with all valid → order again starts at 0; no back-to-back grant to the same id while others wait.
3. Req 1 sends 0x55 with uart_full held high for 5 cycles → no uart_wr_en and req_ready[1]=0 for those 5 cycles; 0x55 is written on the first cycle full drops.
4. MAX_BURST=4, req 2 sends 6 bytes while req 3 is valid → 4 bytes from req 2, then req 3's message, then the remaining 2 bytes of req 2.
5. Reset asserted after 2 of 5 bytes → next cycle state=IDLE, busy=0, all req_ready=0, uart_wr_en=0, grant_id=0.
6. Macro on, TIMEOUT_CYCLES=8, grantee drops valid after 1 byte → timeout_err pulses exactly 8 cycles later, grant passes to the next valid requester. Macro off, same stimulus → grant held, timeout_err stays 0.
